// File: rtl/mitch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mitch_pkg
// Brief    : Shared widths, constants, log-operand type and leading-one
//            helpers for the Mitchell-log divider.
// Revision : 1.0 - initial release
// ============================================================================
package mitch_pkg;

    localparam int W  = 6;
    localparam int F  = W - 1;
    localparam int QF = 16;

    localparam logic [31:0] c_q_pos_sat = 32'h7FFF_FFFF;
    localparam logic [31:0] c_q_neg_sat = 32'h8000_0000;
    localparam logic [31:0] c_q_zero    = 32'h0000_0000;

    typedef struct packed {
        logic [3:0]   k;
        logic [F-1:0] f;
        logic         zero;
    } log_op_t;

    // One-hot of the most significant set bit (all zeros for a zero input).
    function automatic logic [15:0] lod16(input logic [15:0] v);
        logic [15:0] oh;
        oh = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) oh = 16'(1) << i;
        end
        return oh;
    endfunction

    function automatic logic [3:0] penc16(input logic [15:0] oh);
        logic [3:0] k;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) k = k | 4'(i);
        end
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mitch_log16.sv
`default_nettype none
// ============================================================================
// Module   : mitch_log16
// Brief    : Combinational Mitchell log of a signed 16-bit operand: magnitude,
//            leading-one index and normalised F-bit fraction.
//            MITCH_DIV_ROUND_EN selects round-to-nearest of the fraction.
// Revision : 1.0 - initial release
// ============================================================================
module mitch_log16
    import mitch_pkg::*;
(
    input  logic [15:0] i_v,
    output log_op_t     o_op
);

    logic [15:0]  w_mag;
    logic [3:0]   w_k;
    logic [F-1:0] w_f;

    // Ones'-complement magnitude; -1 would collapse to zero so it is forced to 1.
    always_comb begin
        w_mag = i_v ^ {16{i_v[15]}};
        if (i_v == 16'hFFFF) w_mag = 16'd1;
    end

    assign w_k = penc16(lod16(w_mag));

`ifdef MITCH_DIV_ROUND_EN
    localparam int c_fr_w = F + 1;

    logic [F:0] w_fr;
    logic [F:0] w_sum;

    // Fraction bits plus the first discarded bit below them.
    assign w_fr  = c_fr_w'((w_mag << (4'd15 - w_k)) >> (15 - F - 1));
    assign w_sum = {1'b0, w_fr[F:1]} + {{F{1'b0}}, w_fr[0]};
    assign w_f   = w_sum[F] ? {F{1'b1}} : w_sum[F-1:0];
`else
    assign w_f = F'((w_mag << (4'd15 - w_k)) >> (15 - F));
`endif

    assign o_op = '{k: w_k, f: w_f, zero: (i_v == 16'd0)};

endmodule
`default_nettype wire

// File: rtl/mitch_div_w6_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mitch_div_w6_pipe
// Brief    : Three-stage approximate signed 16/16 divider (Mitchell log,
//            subtract, antilog) producing a Q16.16 quotient behind a
//            valid/ready stream. MITCH_DIV_ROUND_EN enables fraction rounding.
// Revision : 1.0 - initial release
// ============================================================================
module mitch_div_w6_pipe
    import mitch_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      x_i,
    input  logic [15:0]      y_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      q_o,
    output logic             dz_o,
    output logic [TAG_W-1:0] tag_o
);

    log_op_t w_lx;
    log_op_t w_ly;

    logic w_s1_ready;
    logic w_s2_ready;
    logic w_s3_ready;

    logic             r_s1_valid;
    log_op_t          r_s1_lx;
    log_op_t          r_s1_ly;
    logic             r_s1_sign;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [5:0]       r_s2_e;
    logic [W-1:0]     r_s2_m;
    logic             r_s2_sign;
    logic             r_s2_dz;
    logic             r_s2_qz;
    logic [TAG_W-1:0] r_s2_tag;

    logic             r_s3_valid;
    logic [31:0]      r_s3_q;
    logic             r_s3_dz;
    logic [TAG_W-1:0] r_s3_tag;

    logic [5:0]  w_e;
    logic [F:0]  w_d;
    logic [5:0]  w_ep;
    logic [W-1:0] w_m;
    logic [6:0]  w_sh;
    logic [5:0]  w_lsh;
    logic [5:0]  w_rsh;
    logic [31:0] w_mag;
    logic [31:0] w_q;

    mitch_log16 u_log_x (.i_v(x_i), .o_op(w_lx));
    mitch_log16 u_log_y (.i_v(y_i), .o_op(w_ly));

    // Each stage can take new data when empty or when its successor frees up.
    assign w_s3_ready = ~r_s3_valid | out_ready_i;
    assign w_s2_ready = ~r_s2_valid | w_s3_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;
    assign in_ready_o = w_s1_ready;

    assign w_e  = {2'b00, r_s1_lx.k} - {2'b00, r_s1_ly.k};
    assign w_d  = {1'b0, r_s1_lx.f} - {1'b0, r_s1_ly.f};
    assign w_ep = w_e - {5'b0, w_d[F]};
    assign w_m  = {1'b1, w_d[F-1:0]};

    assign w_sh  = {r_s2_e[5], r_s2_e} + 7'(QF - F);
    assign w_lsh = w_sh[5:0];
    assign w_rsh = 6'(7'd0 - w_sh);
    assign w_mag = w_sh[6] ? (32'(r_s2_m) >> w_rsh) : (32'(r_s2_m) << w_lsh);

    always_comb begin
        w_q = r_s2_sign ? (32'd0 - w_mag) : w_mag;
        if (r_s2_dz) begin
            w_q = r_s2_sign ? c_q_neg_sat : c_q_pos_sat;
        end else if (r_s2_qz) begin
            w_q = c_q_zero;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_valid <= 1'b0;
            r_s1_lx    <= '0;
            r_s1_ly    <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_lx   <= w_lx;
                r_s1_ly   <= w_ly;
                r_s1_sign <= x_i[15] ^ y_i[15];
                r_s1_tag  <= tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s2_valid <= 1'b0;
            r_s2_e     <= '0;
            r_s2_m     <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_dz    <= 1'b0;
            r_s2_qz    <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_e    <= w_ep;
                r_s2_m    <= w_m;
                r_s2_sign <= r_s1_sign;
                r_s2_dz   <= r_s1_ly.zero;
                r_s2_qz   <= r_s1_lx.zero & ~r_s1_ly.zero;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s3_valid <= 1'b0;
            r_s3_q     <= '0;
            r_s3_dz    <= 1'b0;
            r_s3_tag   <= '0;
        end else if (w_s3_ready) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_q   <= w_q;
                r_s3_dz  <= r_s2_dz;
                r_s3_tag <= r_s2_tag;
            end
        end
    end

    assign out_valid_o = r_s3_valid;
    assign q_o         = r_s3_q;
    assign dz_o        = r_s3_dz;
    assign tag_o       = r_s3_tag;

endmodule
`default_nettype wire
